// File: rtl/clk_div_checker_if.sv
// ---------------------------------------------------------------------------
// clk_div_checker_if : control/status bundle of the divided-clock checker
// Revision 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface clk_div_checker_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             div_in;
  logic [CNT_W-1:0] exp_div;
  logic             err_clr;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_cnt;
  logic             meas_vld;
  logic             locked;
  logic [2:0]       err_code;

  modport master (
    output en, div_in, exp_div, err_clr,
    input  period, high_cnt, meas_vld, locked, err_code
  );

  modport slave (
    input  en, div_in, exp_div, err_clr,
    output period, high_cnt, meas_vld, locked, err_code
  );
endinterface

`default_nettype wire

// File: rtl/clk_div_checker.sv
// ---------------------------------------------------------------------------
// clk_div_checker : measures period/high time of a divided clock, checks them
// against the expected ratio and reports lock plus sticky error flags.
// Revision 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module clk_div_checker #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic              clk,
  input  logic              rst,
  clk_div_checker_if.slave  bus
);

  localparam int               MATCH_W   = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [MATCH_W-1:0] LOCK_VAL = MATCH_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEAS      = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic div_m;
  logic div_s;
  logic div_d;
  logic rise;

  logic [CNT_W-1:0]   per_cnt;
  logic [CNT_W-1:0]   hi_cnt;
  logic [CNT_W-1:0]   per_nxt;
  logic [CNT_W-1:0]   hi_nxt;
  logic [MATCH_W-1:0] match_cnt;
  logic [MATCH_W-1:0] match_nxt;
  logic [MATCH_W-1:0] match_inc;

  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_cnt;
  logic             meas_vld;
  logic             locked;
  logic             locked_nxt;
  logic [2:0]       err_code;
  logic [2:0]       err_set;
  logic [2:0]       err_nxt;

  logic             meas_evt;
  logic             timeout;
  logic             per_bad;
  logic             duty_bad;
  logic [CNT_W:0]   exp_p1;
  logic [CNT_W-1:0] half_lo;
  logic [CNT_W-1:0] half_hi;

  // two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_m <= 1'b0;
      div_s <= 1'b0;
      div_d <= 1'b0;
    end else begin
      div_m <= bus.div_in;
      div_s <= div_m;
      div_d <= div_s;
    end
  end

  assign rise = div_s & ~div_d;

  assign meas_evt = bus.en && (state == MEAS) && rise;
  assign timeout  = bus.en && (state == MEAS) && !rise && (per_cnt == CNT_MAX);

  // acceptable high time is floor(N/2) or ceil(N/2); widen so N+1 cannot wrap
  assign exp_p1   = {1'b0, bus.exp_div} + {{CNT_W{1'b0}}, 1'b1};
  assign half_lo  = bus.exp_div >> 1;
  assign half_hi  = exp_p1[CNT_W:1];
  assign per_bad  = (per_cnt != bus.exp_div);
  assign duty_bad = (hi_cnt != half_lo) && (hi_cnt != half_hi);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (bus.en) state_nxt = WAIT_EDGE;
      WAIT_EDGE: if (rise)   state_nxt = MEAS;
      MEAS:      if (timeout) state_nxt = WAIT_EDGE;
      default:   state_nxt = IDLE;
    endcase
    if (!bus.en) begin
      state_nxt = IDLE;
    end
  end

  // period/high counters restart on every rise and saturate instead of wrapping
  always_comb begin
    per_nxt = per_cnt;
    hi_nxt  = hi_cnt;
    if (bus.en && rise && ((state == WAIT_EDGE) || (state == MEAS))) begin
      per_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
      hi_nxt  = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (bus.en && (state == MEAS)) begin
      if (per_cnt != CNT_MAX) begin
        per_nxt = per_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if ((hi_cnt != CNT_MAX) && div_s) begin
        hi_nxt = hi_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else begin
      per_cnt <= per_nxt;
      hi_cnt  <= hi_nxt;
    end
  end

  always_comb begin
    match_inc  = (match_cnt == LOCK_VAL) ? LOCK_VAL
                                         : match_cnt + {{(MATCH_W-1){1'b0}}, 1'b1};
    match_nxt  = match_cnt;
    locked_nxt = locked;
    if (!bus.en || timeout) begin
      match_nxt  = '0;
      locked_nxt = 1'b0;
    end else if (meas_evt) begin
      if (!per_bad && !duty_bad) begin
        match_nxt  = match_inc;
        locked_nxt = (match_inc == LOCK_VAL);
      end else begin
        match_nxt  = '0;
        locked_nxt = 1'b0;
      end
    end
  end

  // a concurrent set wins over err_clr for the same bit
  always_comb begin
    err_set = {timeout, meas_evt & duty_bad, meas_evt & per_bad};
    err_nxt = (err_code & ~{3{bus.err_clr}}) | err_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt <= '0;
      locked    <= 1'b0;
      err_code  <= 3'b000;
      meas_vld  <= 1'b0;
      period    <= '0;
      high_cnt  <= '0;
    end else begin
      match_cnt <= match_nxt;
      locked    <= locked_nxt;
      err_code  <= err_nxt;
      meas_vld  <= meas_evt;
      if (meas_evt) begin
        period   <= per_cnt;
        high_cnt <= hi_cnt;
      end
    end
  end

  assign bus.period   = period;
  assign bus.high_cnt = high_cnt;
  assign bus.meas_vld = meas_vld;
  assign bus.locked   = locked;
  assign bus.err_code = err_code;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_checker.sv
// ---------------------------------------------------------------------------
// tb_clk_div_checker : randomized and directed bench for clk_div_checker with
// an edge-history reference model compared every cycle.
// Revision 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_clk_div_checker;

  localparam int CNT_W = 4;
  localparam int LOCK  = 4;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  clk_div_checker_if #(.CNT_W(CNT_W)) bus ();

  clk_div_checker #(.CNT_W(CNT_W), .LOCK_CNT(LOCK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // waveform generator in half-clock steps, so edges land on either clk edge
  int g_per = 18;
  int g_hi  = 9;
  int g_ph  = 0;
  bit g_on  = 1'b0;
  bit g_lvl = 1'b0;
  int p_per = 18;
  int p_hi  = 9;
  bit p_req = 1'b0;

  initial begin
    bus.div_in = 1'b0;
    forever begin
      @(clk);
      #1;
      if (g_on) begin
        g_ph++;
        if (g_ph >= g_per) begin
          g_ph = 0;
          if (p_req) begin
            g_per = p_per;
            g_hi  = p_hi;
            p_req = 1'b0;
          end
        end
        bus.div_in = (g_ph < g_hi);
      end else begin
        bus.div_in = g_lvl;
      end
    end
  end

  // reference model: measurements derived from the history of posedge samples
  bit       hist[int];
  int       e;
  bit       active, refv;
  int       ref_e, ones, match;
  int       m_period, m_high;
  bit       m_vld, m_locked;
  bit [2:0] m_err;

  function automatic bit h(input int i);
    return (i >= 0 && hist.exists(i)) ? hist[i] : 1'b0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        hist.delete();
        e = 0; active = 0; refv = 0; ref_e = 0; ones = 0; match = 0;
        m_period = 0; m_high = 0; m_vld = 0; m_locked = 0; m_err = 3'b000;
      end else begin
        bit       r;
        bit [2:0] set;
        int       ex, p;
        hist[e] = bus.div_in;
        r   = h(e-2) && !h(e-3);
        ex  = int'(bus.exp_div);
        set = 3'b000;
        m_vld = 1'b0;
        if (!bus.en) begin
          active = 0; refv = 0; match = 0; m_locked = 0;
        end else if (!active) begin
          active = 1; refv = 0;
        end else if (r) begin
          if (refv) begin
            p = e - ref_e;
            m_period = p;
            m_high   = ones;
            m_vld    = 1'b1;
            set[0] = (p != ex);
            set[1] = (ones != ex / 2) && (ones != (ex + 1) / 2);
            if (set[1:0] == 2'b00) begin
              match    = (match + 1 > LOCK) ? LOCK : match + 1;
              m_locked = (match == LOCK);
            end else begin
              match = 0; m_locked = 0;
            end
          end
          refv = 1; ref_e = e; ones = 1;
        end else if (refv) begin
          if (e - ref_e == MAXV) begin
            set[2] = 1'b1; refv = 0; match = 0; m_locked = 0;
          end else begin
            ones += int'(h(e-2));
          end
        end
        m_err = (bus.err_clr ? 3'b000 : m_err) | set;
        if (hist.exists(e-8)) hist.delete(e-8);
        e++;
      end
    end
  end

  function automatic int pack_dut();
    return {19'd0, bus.meas_vld, bus.locked, bus.err_code, bus.period, bus.high_cnt};
  endfunction

  function automatic int pack_model();
    return {19'd0, m_vld, m_locked, m_err, 4'(m_period), 4'(m_high)};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      check("cycle{vld,lock,err,per,hi}", pack_dut(), pack_model());
    end
  end

  task automatic wait_meas(input int budget, input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.meas_vld && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!bus.meas_vld) begin
      total++;
      bad++;
      $display("FAIL %s: no meas_vld within %0d cycles", tag, budget);
    end
  endtask

  task automatic set_wave(input int per, input int hi);
    g_per = per; g_hi = hi; g_ph = 0; g_on = 1'b1;
  endtask

  task automatic switch_wave(input int per, input int hi);
    int k;
    p_per = per; p_hi = hi; p_req = 1'b1;
    k = 0;
    while (p_req && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (p_req) begin
      total++;
      bad++;
      $display("FAIL switch_wave: waveform change not applied");
    end
  endtask

  task automatic pulse_clr();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
  endtask

  task automatic count_vld(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.meas_vld) n++;
    end
  endtask

  initial begin
    int n;
    int saved;
    bus.en      = 1'b0;
    bus.err_clr = 1'b0;
    bus.exp_div = 4'd9;

    repeat (2) @(negedge clk);
    check("reset_outputs", pack_dut(), 0);
    rst = 1'b0;

    // odd ratio 9, 50% duty
    set_wave(18, 9);
    bus.en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wait_meas(40, "odd9");
      if (i == 3) check("odd9_not_locked_yet", int'(bus.locked), 0);
    end
    check("odd9_locked", int'(bus.locked), 1);
    check("odd9_period", int'(bus.period), 9);
    check("odd9_high_in_4_5", int'(bus.high_cnt == 4 || bus.high_cnt == 5), 1);
    check("odd9_err", int'(bus.err_code), 0);

    // mismatch: switch to divide by 7 while locked
    switch_wave(14, 7);
    wait_meas(40, "mm_old");
    wait_meas(40, "mm_new");
    check("mm_period", int'(bus.period), 7);
    check("mm_err0", int'(bus.err_code[0]), 1);
    check("mm_locked", int'(bus.locked), 0);

    // en drop, clear, even ratio 4
    bus.en = 1'b0;
    pulse_clr();
    check("clr_err", int'(bus.err_code), 0);
    bus.exp_div = 4'd4;
    set_wave(8, 4);
    bus.en = 1'b1;
    repeat (4) wait_meas(30, "even4");
    check("even4_period", int'(bus.period), 4);
    check("even4_high", int'(bus.high_cnt), 2);
    check("even4_locked", int'(bus.locked), 1);
    check("even4_err", int'(bus.err_code), 0);

    // duty error: divide by 9 with 2-cycle high
    bus.en = 1'b0;
    bus.exp_div = 4'd9;
    set_wave(18, 4);
    @(negedge clk);
    bus.en = 1'b1;
    repeat (2) wait_meas(40, "duty");
    check("duty_period", int'(bus.period), 9);
    check("duty_high", int'(bus.high_cnt), 2);
    check("duty_err1", int'(bus.err_code[1]), 1);
    check("duty_locked", int'(bus.locked), 0);

    // err_clr held across a new mismatch: set must win
    bus.en = 1'b0;
    pulse_clr();
    set_wave(18, 9);
    bus.en = 1'b1;
    repeat (4) wait_meas(40, "relock");
    check("relock_locked", int'(bus.locked), 1);
    switch_wave(14, 7);
    wait_meas(40, "clrset_old");
    bus.err_clr = 1'b1;
    wait_meas(40, "clrset_new");
    bus.err_clr = 1'b0;
    check("clr_vs_set_err0", int'(bus.err_code[0]), 1);

    // timeout after a single rise
    bus.en = 1'b0;
    g_on = 1'b0; g_lvl = 1'b0;
    pulse_clr();
    bus.en = 1'b1;
    repeat (4) @(negedge clk);
    g_lvl = 1'b1; repeat (2) @(negedge clk);
    g_lvl = 1'b0;
    count_vld(24, n);
    check("to_no_vld", n, 0);
    check("to_err2", int'(bus.err_code[2]), 1);
    check("to_locked", int'(bus.locked), 0);
    g_lvl = 1'b1; repeat (2) @(negedge clk);
    g_lvl = 1'b0; repeat (4) @(negedge clk);
    g_lvl = 1'b1; repeat (2) @(negedge clk);
    g_lvl = 1'b0;
    wait_meas(10, "to_restart");
    check("to_restart_period", int'(bus.period), 6);
    check("to_restart_high", int'(bus.high_cnt), 2);

    // asynchronous reset mid-period
    set_wave(18, 9);
    repeat (2) wait_meas(40, "pre_rst");
    @(negedge clk);
    #3 rst = 1'b1;
    #1 check("async_rst_outputs", pack_dut(), 0);
    @(negedge clk);
    rst = 1'b0;

    // en dropped mid-period
    repeat (5) wait_meas(40, "pre_abort");
    check("abort_pre_locked", int'(bus.locked), 1);
    saved = int'(bus.err_code);
    repeat (4) @(negedge clk);
    bus.en = 1'b0;
    count_vld(20, n);
    check("abort_no_vld", n, 0);
    check("abort_locked", int'(bus.locked), 0);
    check("abort_err_held", int'(bus.err_code), saved);
    check("abort_period_held", int'(bus.period), 9);

    // randomized waveforms, ratios, clears and stalls
    for (int it = 0; it < 12; it++) begin
      int nr;
      bus.en = 1'b0;
      if ($urandom_range(0, 1) == 1) pulse_clr();
      nr = $urandom_range(2, 14);
      bus.exp_div = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(2, 14)) : 4'(nr);
      set_wave(2 * nr, $urandom_range(1, 2 * nr - 1));
      @(negedge clk);
      bus.en = 1'b1;
      for (int c = 0; c < 90; c++) begin
        @(negedge clk);
        bus.err_clr = ($urandom_range(0, 15) == 0);
        if (c == 60 && $urandom_range(0, 3) == 0) begin
          g_lvl = bus.div_in;
          g_on  = 1'b0;
        end
      end
      bus.err_clr = 1'b0;
    end

    bus.en = 1'b0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clk_div_checker.md
CLK_DIV_CHECKER -- requirements
Module: clk_div_checker

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the width of the period and high-time counters.
REQ-002 SHALL have parameter LOCK_CNT, default 4, giving the number of consecutive good periods needed to assert locked.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is posedge-clk.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: enables monitoring.
REQ-006 SHALL have port div_in, input, 1 bit: the divided clock under test, with edges on either clk edge.
REQ-007 SHALL have port exp_div, input, CNT_W bits: the expected divide ratio N; legal values are 2 to 2^CNT_W-2, held stable while en=1.
REQ-008 SHALL have port err_clr, input, 1 bit: a single-cycle pulse that clears err_code.
REQ-009 SHALL have port period, output, CNT_W bits: the last measured period in clk cycles.
REQ-010 SHALL have port high_cnt, output, CNT_W bits: the last measured high time, in posedge samples.
REQ-011 SHALL have port meas_vld, output, 1 bit: a one-cycle pulse when period and high_cnt update.
REQ-012 SHALL have port locked, output, 1 bit: asserted after LOCK_CNT consecutive good periods.
REQ-013 SHALL have port err_code, output, 3 bits, sticky: bit0 = period mismatch, bit1 = duty error, bit2 = timeout.

Function
REQ-014 SHALL pass div_in through a 2-flop synchronizer (div_s) and then one delay flop (div_d); rise = div_s & ~div_d.
REQ-015 SHALL implement an FSM with states IDLE, WAIT_EDGE and MEAS.
- IDLE -> WAIT_EDGE when en=1.
- WAIT_EDGE -> MEAS on rise.
- MEAS -> WAIT_EDGE on timeout.
- Any state -> IDLE when en=0.
REQ-016 SHALL, on a rise cycle (in WAIT_EDGE or MEAS), load per_cnt=1 and hi_cnt=1.
REQ-017 SHALL, on each non-rise cycle in MEAS, increment per_cnt by 1 and increment hi_cnt by div_s.
REQ-018 SHALL, on a rise cycle in MEAS, latch the pre-reload per_cnt into period and hi_cnt into high_cnt, and pulse meas_vld in the following cycle, aligned with the updated outputs.
REQ-019 SHALL treat a measurement as good iff period == exp_div and high_cnt is in {exp_div>>1, (exp_div+1)>>1}.
REQ-020 SHALL, on a good measurement, increment match_cnt (saturating at LOCK_CNT) and assert locked when match_cnt reaches LOCK_CNT.
REQ-021 SHALL, on period != exp_div, set err_code[0], clear match_cnt and deassert locked in the cycle meas_vld pulses.
REQ-022 SHALL, on a duty-range violation, set err_code[1], clear match_cnt and deassert locked, in the same cycle as REQ-021.
REQ-023 SHALL, when per_cnt reaches 2^CNT_W-1 in MEAS without a rise, declare timeout.
- Sets err_code[2].
- Clears locked and match_cnt.
- Moves to WAIT_EDGE.
- Does not pulse meas_vld.
REQ-024 SHALL ensure per_cnt and hi_cnt never wrap, saturating at all-ones.
REQ-025 SHALL, when err_clr and a new error set occur in the same cycle, give priority to set (the bit remains 1); err_clr clears only bits with no concurrent set.
REQ-026 SHALL, on en deassertion mid-measurement, abandon the partial period: no meas_vld, locked and match_cnt cleared, period/high_cnt/err_code held.
REQ-027 SHALL, on exp_div change while en=1, leave behaviour undefined; software SHALL toggle en.

Reset
REQ-028 SHALL, on rst=1 asynchronously, force FSM=IDLE, synchronizer/delay flops=0, per_cnt=hi_cnt=match_cnt=0, period=high_cnt=0, meas_vld=0, locked=0 and err_code=3'b000.
REQ-029 SHALL, on rst deassertion, begin operation on the next posedge clk; the first rise after en requires one full period before the first meas_vld.

Verification
REQ-030 SHALL cover odd ratio: div_in = 50% odd divide by 9 (posedge/negedge-combined), exp_div=9, en=1 -> every meas_vld shows period=9 and high_cnt in {4,5}; locked=1 after the 4th good meas_vld; err_code=0.
REQ-031 SHALL cover even ratio: divide by 4, 50% duty, exp_div=4 -> period=4, high_cnt=2, locked after 4 periods.
REQ-032 SHALL cover mismatch: locked on divide by 9, then div_in switched to divide by 7 -> next meas_vld has period=7, err_code[0]=1, locked=0 in the same cycle.
REQ-033 SHALL cover duty error: divide by 9 with high for 2 cycles -> period=9, high_cnt=2, err_code[1]=1, locked=0.
REQ-034 SHALL cover timeout: CNT_W=4, div_in held 0 after one rise -> err_code[2]=1 when per_cnt reaches 15, no meas_vld, FSM returns to WAIT_EDGE; a subsequent rise restarts measurement.
REQ-035 SHALL cover reset and en abort: rst asserted mid-period -> all outputs 0 immediately; en dropped mid-period -> no meas_vld, locked=0, err_code unchanged; err_clr coincident with a new mismatch -> err_code[0] stays 1.
